// File: rtl/alu_checker.sv
// Response checker for the Hack ALU: registered golden model, response compare,
// saturating pass/fail counters, sticky error, first-failure capture and coverage.
module alu_checker #(
    parameter int unsigned CNT_W       = 16,
    parameter bit          HALT_ON_ERR = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             sample,
    input  logic [15:0]      x,
    input  logic [15:0]      y,
    input  logic [5:0]       ctl,
    input  logic [15:0]      dut_out,
    input  logic             dut_zr,
    input  logic             dut_ng,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err,
    output logic             halted,
    output logic [17:0]      cov,
    output logic [5:0]       fail_ctl,
    output logic [15:0]      fail_x,
    output logic [15:0]      fail_y,
    output logic [15:0]      fail_exp,
    output logic [15:0]      fail_got
);
    localparam int unsigned DW   = 16;
    localparam int unsigned CW   = 6;
    localparam int unsigned NCOV = 18;

    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    state_t            state_q, state_d;
    logic              s1_vld_q, s1_vld_d;
    logic [CW-1:0]     s1_ctl_q, s1_ctl_d;
    logic [DW-1:0]     s1_x_q, s1_x_d, s1_y_q, s1_y_d;
    logic [DW-1:0]     s1_exp_q, s1_exp_d, s1_got_q, s1_got_d;
    logic              s1_zr_q, s1_zr_d, s1_ng_q, s1_ng_d;
    logic [CNT_W-1:0]  pass_q, pass_d, fail_q, fail_d;
    logic              err_q, err_d, halted_q, halted_d;
    logic [NCOV-1:0]   cov_q, cov_d;
    logic [CW-1:0]     fctl_q, fctl_d;
    logic [DW-1:0]     fx_q, fx_d, fy_q, fy_d, fexp_q, fexp_d, fgot_q, fgot_d;

    logic [DW-1:0]     xa_c, xb_c, ya_c, yb_c, r_c, exp_c;
    logic              match_c, check_c, accept_c;

    // One-hot coverage bit for a canonical Hack computation, zero otherwise.
    function automatic logic [NCOV-1:0] cov_hit(input logic [CW-1:0] c);
        logic [NCOV-1:0] hit;
        hit = '0;
        case (c)
            6'b101010: hit[0]  = 1'b1;
            6'b111111: hit[1]  = 1'b1;
            6'b111010: hit[2]  = 1'b1;
            6'b001100: hit[3]  = 1'b1;
            6'b110000: hit[4]  = 1'b1;
            6'b001101: hit[5]  = 1'b1;
            6'b110001: hit[6]  = 1'b1;
            6'b001111: hit[7]  = 1'b1;
            6'b110011: hit[8]  = 1'b1;
            6'b011111: hit[9]  = 1'b1;
            6'b110111: hit[10] = 1'b1;
            6'b001110: hit[11] = 1'b1;
            6'b110010: hit[12] = 1'b1;
            6'b000010: hit[13] = 1'b1;
            6'b010011: hit[14] = 1'b1;
            6'b000111: hit[15] = 1'b1;
            6'b000000: hit[16] = 1'b1;
            6'b010101: hit[17] = 1'b1;
            default:   hit     = '0;
        endcase
        return hit;
    endfunction

    // Golden ALU evaluated on the incoming operands, registered at E1.
    always_comb begin
        xa_c  = ctl[5] ? '0 : x;
        xb_c  = ctl[4] ? ~xa_c : xa_c;
        ya_c  = ctl[3] ? '0 : y;
        yb_c  = ctl[2] ? ~ya_c : ya_c;
        r_c   = ctl[1] ? DW'(xb_c + yb_c) : (xb_c & yb_c);
        exp_c = ctl[0] ? ~r_c : r_c;
    end

    assign match_c = (s1_got_q == s1_exp_q) && (s1_zr_q == (s1_exp_q == '0))
                     && (s1_ng_q == s1_exp_q[DW-1]);

    always_comb begin
        state_d  = state_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        err_d    = err_q;
        cov_d    = cov_q;
        fctl_d   = fctl_q;
        fx_d     = fx_q;
        fy_d     = fy_q;
        fexp_d   = fexp_q;
        fgot_d   = fgot_q;
        s1_ctl_d = s1_ctl_q;
        s1_x_d   = s1_x_q;
        s1_y_d   = s1_y_q;
        s1_exp_d = s1_exp_q;
        s1_got_d = s1_got_q;
        s1_zr_d  = s1_zr_q;
        s1_ng_d  = s1_ng_q;
        check_c  = s1_vld_q && (state_q != HALTED);

        if (check_c) begin
            if (match_c) begin
                pass_d = (pass_q == '1) ? pass_q : pass_q + CNT_W'(1);
                cov_d  = cov_q | cov_hit(s1_ctl_q);
            end else begin
                fail_d = (fail_q == '1) ? fail_q : fail_q + CNT_W'(1);
                if (!err_q) begin
                    err_d  = 1'b1;
                    fctl_d = s1_ctl_q;
                    fx_d   = s1_x_q;
                    fy_d   = s1_y_q;
                    fexp_d = s1_exp_q;
                    fgot_d = s1_got_q;
                end
                if (HALT_ON_ERR) state_d = HALTED;
            end
        end

        // A sample arriving on the halting edge is dropped along with it.
        accept_c = sample && (state_d != HALTED);
        s1_vld_d = accept_c;
        if (accept_c) begin
            s1_ctl_d = ctl;
            s1_x_d   = x;
            s1_y_d   = y;
            s1_exp_d = exp_c;
            s1_got_d = dut_out;
            s1_zr_d  = dut_zr;
            s1_ng_d  = dut_ng;
            if (state_q == IDLE) state_d = RUN;
        end

        if (clear) begin
            state_d  = IDLE;
            s1_vld_d = 1'b0;
            pass_d   = '0;
            fail_d   = '0;
            err_d    = 1'b0;
            cov_d    = '0;
            fctl_d   = '0;
            fx_d     = '0;
            fy_d     = '0;
            fexp_d   = '0;
            fgot_d   = '0;
            s1_ctl_d = '0;
            s1_x_d   = '0;
            s1_y_d   = '0;
            s1_exp_d = '0;
            s1_got_d = '0;
            s1_zr_d  = 1'b0;
            s1_ng_d  = 1'b0;
        end
        halted_d = (state_d == HALTED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            s1_vld_q <= 1'b0;
            s1_ctl_q <= '0;
            s1_x_q   <= '0;
            s1_y_q   <= '0;
            s1_exp_q <= '0;
            s1_got_q <= '0;
            s1_zr_q  <= 1'b0;
            s1_ng_q  <= 1'b0;
            pass_q   <= '0;
            fail_q   <= '0;
            err_q    <= 1'b0;
            halted_q <= 1'b0;
            cov_q    <= '0;
            fctl_q   <= '0;
            fx_q     <= '0;
            fy_q     <= '0;
            fexp_q   <= '0;
            fgot_q   <= '0;
        end else begin
            state_q  <= state_d;
            s1_vld_q <= s1_vld_d;
            s1_ctl_q <= s1_ctl_d;
            s1_x_q   <= s1_x_d;
            s1_y_q   <= s1_y_d;
            s1_exp_q <= s1_exp_d;
            s1_got_q <= s1_got_d;
            s1_zr_q  <= s1_zr_d;
            s1_ng_q  <= s1_ng_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            err_q    <= err_d;
            halted_q <= halted_d;
            cov_q    <= cov_d;
            fctl_q   <= fctl_d;
            fx_q     <= fx_d;
            fy_q     <= fy_d;
            fexp_q   <= fexp_d;
            fgot_q   <= fgot_d;
        end
    end

    assign pass_cnt = pass_q;
    assign fail_cnt = fail_q;
    assign err      = err_q;
    assign halted   = halted_q;
    assign cov      = cov_q;
    assign fail_ctl = fctl_q;
    assign fail_x   = fx_q;
    assign fail_y   = fy_q;
    assign fail_exp = fexp_q;
    assign fail_got = fgot_q;
endmodule

// File: doc/alu_checker.md
# alu_checker

Hardware response checker for the Hack ALU: it consumes the same x/y operands and six control bits that drive the ALU, together with the ALU's out/zr/ng response. It recomputes the expected result with a registered golden model, compares it against the response, and keeps pass/fail counters, a sticky error flag, a first-failure capture and a coverage bitmap of the 18 canonical Hack computations. It sits beside the ALU in on-chip self-test and FPGA bring-up builds, at the receiving end of the ALU stimulus stream.

## Interface
- CNT_W, 16: width of pass/fail counters; both saturate at all-ones.
- HALT_ON_ERR, 1: 1 = stop checking after the first mismatch; 0 = keep checking.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous clear of all state, counters and pipeline.
- sample  in  1  qualifies the current x/y/ctl/dut_* as one check.
- x, y  in  16 each  ALU operands.
- ctl  in  6  {zx,nx,zy,ny,f,no}; zx is bit 5.
- dut_out  in  16  ALU result; dut_zr, dut_ng  in  1 each  ALU flags.
- pass_cnt, fail_cnt  out  CNT_W  matched / mismatched checks.
- err  out  1  sticky; set on first mismatch.
- halted  out  1  high in state HALTED.
- cov  out  18  bit i set once canonical computation i has passed.
- fail_ctl  out  6; fail_x, fail_y, fail_exp, fail_got  out  16 each  first-failure capture; fail_exp/fail_got hold the 16-bit result.

## Operation
- Golden model, stage-1 registers: xa = zx?0:x; xb = nx?~xa:xa; same for y with zy/ny; r = f ? (xb+yb) mod 2^16 : xb&yb; exp = no?~r:r; exp_zr = (exp==0); exp_ng = exp[15].
- A check passes only if dut_out==exp, dut_zr==exp_zr and dut_ng==exp_ng.
- Coverage index and ctl code:
  - 0: 0=101010; 1: 1=111111; 2: -1=111010; 3: x=001100; 4: y=110000
  - 5: !x=001101; 6: !y=110001; 7: -x=001111; 8: -y=110011
  - 9: x+1=011111; 10: y+1=110111; 11: x-1=001110; 12: y-1=110010
  - 13: x+y=000010; 14: x-y=010011; 15: y-x=000111; 16: x&y=000000; 17: x|y=010101
- Non-canonical ctl codes are still checked and counted, but set no cov bit.
- FSM states:
  - IDLE: after reset or clear; goes to RUN when the first sample is registered.
  - RUN: checking.
  - HALTED: entered on a mismatch when HALT_ON_ERR=1. Samples are ignored and in-flight results are discarded. Leaves only via clear or reset, both of which go to IDLE.
- On the first mismatch, err is set and fail_* are captured. Later mismatches increment fail_cnt only; the capture is never overwritten until clear.

## Timing
- Pipeline: edge E1 registers sample data into stage 1. During the following cycle the compare is combinational. Edge E2 updates the counters, err, cov and fail_*. Latency is 2 edges, throughput is 1 check per cycle, there is no backpressure.
- Reset (async, rst_n low) and clear (sync) give: pass_cnt=0, fail_cnt=0, err=0, halted=0, cov=0, fail_*=0, stage-1 valid=0, state IDLE.
- clear and sample in the same cycle: clear wins and the sample is dropped.
- clear while a check is in stage 1: the result is discarded.
- rst_n asserted mid-stream: outputs clear immediately, without waiting for clk.
- Mismatch on check N with HALT_ON_ERR=1: halted rises at the same edge as err. Check N+1, already in stage 1, is not counted.
- Counter at all-ones plus another event: the counter holds at all-ones.
- Consecutive samples with no gap are all counted; pass_cnt+fail_cnt equals the number of samples accepted outside HALTED, until a counter saturates.

## Test plan
- Reset/idle: rst_n low mid-cycle -> all outputs 0 asynchronously. After release with no sample -> state stays IDLE, counters stay 0.
- Full sweep, correct ALU: x=0x0000, y=0xFFFF, all 18 canonical codes back-to-back with correct responses -> pass_cnt=18, fail_cnt=0, cov=0x3FFFF, err=0.
- Values case: x=17, y=3:
  - x-y (010011) expecting 14, zr=0, ng=0 -> pass.
  - y-x (000111) expecting 0xFFF2, ng=1 -> pass.
  - 0 (101010) expecting zr=1 -> pass.
- Injected fault, HALT_ON_ERR=1: x+y with x=17, y=3 and dut_out=21 -> err=1 and halted=1 two edges after the sample; fail_exp=20, fail_got=21, fail_ctl=000010. The next back-to-back sample is not counted. clear -> all state zeroed.
- Flag-only fault, HALT_ON_ERR=0: correct dut_out but dut_zr inverted, on 5 consecutive samples -> fail_cnt=5, err=1, halted=0. fail_* still holds the first failure.
- Saturation and clear collision, CNT_W=4: 20 passing samples -> pass_cnt=15. clear asserted in the same cycle as a sample -> pass_cnt=0 and the sample is not counted.
